toeplitz_deserializer: RTL and testbench

Receive-side counterpart of the extractor's output serializer. Collects the serial bit stream (`qbit` qualified by `qbiten`) back into L-bit words and buffers them in a small FIFO. Words leave through a valid/ready handshake. Sits downstream of the serial link in loopback benches and in the host-side capture path for the Toeplitz extractor output.

---
 rtl/toeplitz_deserializer.sv | 120 ++++++++++++
 tb/tb_toeplitz_deserializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_deserializer.sv
// Serial-to-parallel receiver: packs qbit/qbiten into L-bit words (MSB first) and queues them
// in a DEPTH-entry FIFO with a valid/ready output. Define DESER_WORDCNT_EN to add word_cnt.
module toeplitz_deserializer #(
  parameter int unsigned L     = 128,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         qbit,
  input  logic         qbiten,
  output logic [L-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         ovf,
  input  logic         ovf_clr
`ifdef DESER_WORDCNT_EN
  ,
  output logic [31:0]  word_cnt
`endif
);

  localparam int unsigned BW = $clog2(L);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [BW-1:0] BLast = BW'(L - 1);

  // The oldest shifted bit is never read back, so only L-1 bits are held.
  logic [L-2:0]  sr_q, sr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [L-1:0]  mem_q [DEPTH];

  logic [L-1:0]  word;
  logic          word_done;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  always_comb begin
    word      = {sr_q, qbit};
    word_done = qbiten && (bcnt_q == BLast);
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop       = !empty && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push      = word_done && (!full || pop);
    drop      = word_done && full && !pop;
  end

  always_comb begin
    sr_d     = sr_q;
    bcnt_d   = bcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    if (qbiten) begin
      sr_d   = word[L-2:0];
      bcnt_d = word_done ? '0 : bcnt_q + BW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
    // Overflow takes priority over a simultaneous clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q     <= '0;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      bcnt_q   <= bcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible between pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= word;
    end
  end

  assign dout       = mem_q[rd_ptr_q[PW-1:0]];
  assign dout_valid = !empty;
  assign ovf        = ovf_q;

`ifdef DESER_WORDCNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt_q <= '0;
    end else if (push && reset) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_toeplitz_deserializer.sv
// Self-checking bench for toeplitz_deserializer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expected words.
module tb_toeplitz_deserializer;

  localparam int unsigned L     = 128;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         qbit = 1'b0;
  logic         qbiten = 1'b0;
  logic         dout_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [L-1:0] dout;
  logic         dout_valid;
  logic         ovf;
`ifdef DESER_WORDCNT_EN
  logic [31:0]  word_cnt;
`endif

  always #5 clk = ~clk;

  toeplitz_deserializer #(
    .L     (L),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .qbit       (qbit),
    .qbiten     (qbiten),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef DESER_WORDCNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: collected bits, queued words, sticky flag, accepted-word count.
  bit           mbits[$];
  logic [L-1:0] mq[$];
  bit           movf;
  int unsigned  mwc;
  logic [L-1:0] got[$];

  task automatic model_step();
    logic [L-1:0] w;
    bit           dropped;
    if (!reset) begin
      mbits.delete();
      mq.delete();
      movf  = 1'b0;
      mwc   = 0;
      armed = 1'b1;
      return;
    end
    dropped = 1'b0;
    if (mq.size() != 0 && dout_ready) void'(mq.pop_front());
    if (qbiten) begin
      mbits.push_back(qbit);
      if (mbits.size() == L) begin
        for (int i = 0; i < int'(L); i++) w[L-1-i] = mbits[i];
        mbits.delete();
        if (mq.size() < DEPTH) begin
          mq.push_back(w);
          mwc++;
        end else begin
          dropped = 1'b1;
        end
      end
    end
    if (dropped) movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("valid", L'(dout_valid), L'(mq.size() != 0));
      if (mq.size() != 0) chk("dout", dout, mq[0]);
      chk("ovf", L'(ovf), L'(movf));
`ifdef DESER_WORDCNT_EN
      chk("word_cnt", L'(word_cnt), L'(mwc));
`endif
      if (dout_valid === 1'b1 && dout_ready) got.push_back(dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b);
    qbit   = b;
    qbiten = 1'b1;
    tick();
    qbiten = 1'b0;
  endtask

  task automatic send_bits(input logic [L-1:0] w, input int n, input bit gaps);
    for (int i = int'(L) - 1; i > int'(L) - 1 - n; i--) begin
      if (gaps) while ($urandom_range(0, 1) == 1) tick();
      send_bit(w[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    got.delete();
  endtask

  logic [L-1:0] w_f0, w_0123, wa, wb, wc;
  logic [L-1:0] ws[4];

  initial begin
    w_f0   = {16{8'hF0}};
    w_0123 = {2{64'h0123456789ABCDEF}};
    ws[0]  = {4{32'hDEADBEEF}};
    ws[1]  = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    ws[2]  = 128'h0;
    ws[3]  = {L{1'b1}};
    wa     = {8{16'hA55A}};
    wb     = {4{32'h1234_5678}};
    wc     = {2{64'hFEDC_BA98_7654_3210}};

    // Reset state, then a single continuous word with the consumer ready.
    do_reset();
    chk("rst_valid", L'(dout_valid), '0);
    chk("rst_ovf", L'(ovf), '0);
    dout_ready = 1'b1;
    send_bits(w_f0, L, 1'b0);
    chk("t1_valid", L'(dout_valid), L'(1));
    chk("t1_dout", dout, w_f0);
    chk("t1_ovf", L'(ovf), '0);
    tick();
    chk("t1_pulse", L'(dout_valid), '0);

    // Four back-to-back words arrive in order.
    got.delete();
    for (int k = 0; k < 4; k++) send_bits(ws[k], L, 1'b0);
    idle(2);
    chk("t2_count", L'(got.size()), L'(4));
    for (int k = 0; k < 4; k++) chk("t2_word", got[k], ws[k]);

    // Random gaps between bits do not disturb the words.
    got.delete();
    send_bits(wa, L, 1'b1);
    send_bits(wb, L, 1'b1);
    idle(2);
    chk("t3_count", L'(got.size()), L'(2));
    chk("t3_w0", got[0], wa);
    chk("t3_w1", got[1], wb);

    // Overflow: three words into a two-deep FIFO with no consumer.
    do_reset();
    dout_ready = 1'b0;
    send_bits(wa, L, 1'b0);
    send_bits(wb, L, 1'b0);
    chk("t4_ovf_before", L'(ovf), '0);
    send_bits(wc, L, 1'b0);
    chk("t4_ovf", L'(ovf), L'(1));
    chk("t4_head", dout, wa);
    dout_ready = 1'b1;
    idle(4);
    chk("t4_count", L'(got.size()), L'(2));
    chk("t4_w0", got[0], wa);
    chk("t4_w1", got[1], wb);
`ifdef DESER_WORDCNT_EN
    chk("t4_wcnt", L'(word_cnt), L'(2));
`endif
    chk("t4_ovf_sticky", L'(ovf), L'(1));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", L'(ovf), '0);

    // Reset partway through a word discards the partial bits.
    send_bits(wc, 60, 1'b0);
    do_reset();
    dout_ready = 1'b1;
    send_bits(w_0123, L, 1'b0);
    idle(2);
    chk("t5_count", L'(got.size()), L'(1));
    chk("t5_word", got[0], w_0123);

    // Full FIFO, last bit of a new word coincides with a pop: accepted, no overflow.
    do_reset();
    dout_ready = 1'b0;
    send_bits(wa, L, 1'b0);
    send_bits(wb, L, 1'b0);
    send_bits(wc, L - 1, 1'b0);
    dout_ready = 1'b1;
    send_bit(wc[0]);
    dout_ready = 1'b0;
    chk("t6_ovf", L'(ovf), '0);
    chk("t6_head", dout, wb);
    dout_ready = 1'b1;
    idle(3);
    chk("t6_count", L'(got.size()), L'(3));
    chk("t6_w0", got[0], wa);
    chk("t6_w1", got[1], wb);
    chk("t6_w2", got[2], wc);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
